// File: rtl/chunked_adder_seq_pkg.sv
// adder_pkg: shared state encoding and parameter legality check for chunked_adder_seq
package adder_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   typedef enum logic [1:0] {IDLE = ST_IDLE, BUSY = ST_BUSY, DONE = ST_DONE} state_t;
   function automatic bit chunk_ok(int width, int chunk);
      return chunk > 0 && chunk <= width && width % chunk == 0;
   endfunction
endpackage

// File: rtl/chunked_adder_seq_if.sv
// chunked_adder_seq_if: operand/result handshake bundle; carries sub when CHUNKED_ADDER_ADD_SUB_EN is defined
interface chunked_adder_seq_if #(parameter int WIDTH = 16);
   logic in_valid, in_ready, cin, out_valid, out_ready, cout;
   logic [WIDTH-1:0] a, b, sum;
`ifdef CHUNKED_ADDER_ADD_SUB_EN
   logic sub;
   modport master(output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout);
   modport slave(input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout);
`else
   modport master(output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout);
   modport slave(input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/chunked_adder_seq_chunk_full_adder.sv
// chunk_full_adder: combinational CHUNK-bit slice adder with carry in/out
module chunk_full_adder #(parameter int CHUNK = 4) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             c
);
   assign {c, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
endmodule

// File: rtl/chunked_adder_seq.sv
// chunked_adder_seq: multi-cycle WIDTH-bit adder, CHUNK bits per clock; CHUNKED_ADDER_ADD_SUB_EN adds subtract mode
module chunked_adder_seq
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input logic clk,
   input logic rst,
   chunked_adder_seq_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
   if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_chunk
      $error("chunked_adder_seq: CHUNK must divide WIDTH");
   end
   state_t state;
   logic [WIDTH-1:0] a_sh, b_sh, res, res_nx, b_in;
   logic [CHUNK-1:0] s;
   logic [IW-1:0] idx;
   logic carry, c_in, c;
`ifdef CHUNKED_ADDER_ADD_SUB_EN
   assign b_in = bus.sub ? ~bus.b : bus.b;
   assign c_in = bus.sub | bus.cin;
`else
   assign b_in = bus.b;
   assign c_in = bus.cin;
`endif
   chunk_full_adder #(.CHUNK(CHUNK)) u_slice (
      .a(a_sh[CHUNK-1:0]),
      .b(b_sh[CHUNK-1:0]),
      .cin(carry),
      .s(s),
      .c(c)
   );
   assign res_nx = (res >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
   // Handshake FSM and slice datapath: one CHUNK-bit slice per BUSY cycle, LSB slice first
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         bus.in_ready <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.sum <= '0;
         bus.cout <= 1'b0;
         carry <= 1'b0;
         idx <= '0;
         a_sh <= '0;
         b_sh <= '0;
         res <= '0;
      end else
         case (state)
            IDLE:
               if (bus.in_valid) begin
                  a_sh <= bus.a;
                  b_sh <= b_in;
                  carry <= c_in;
                  idx <= '0;
                  bus.in_ready <= 1'b0;
                  state <= BUSY;
               end
            BUSY: begin
               res <= res_nx;
               a_sh <= a_sh >> CHUNK;
               b_sh <= b_sh >> CHUNK;
               carry <= c;
               idx <= idx + IW'(1);
               if (idx == IW'(NCHUNK - 1)) begin
                  bus.sum <= res_nx;
                  bus.cout <= c;
                  bus.out_valid <= 1'b1;
                  state <= DONE;
               end
            end
            DONE:
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready <= 1'b1;
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: doc/chunked_adder_seq.md
Name: chunked_adder_seq

Overview:
- Parametrised multi-cycle successor to the 16-bit combinational full adder.
- Adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, holding the carry in a register between slices.
- Uses valid/ready handshakes on input and output.
- Used where a full-width ripple path does not meet timing; trades latency for a short critical path.

Parameters:
- WIDTH, 16, operand and sum width in bits.
- CHUNK, 4, bits added per cycle. Must divide WIDTH exactly; a violation is an elaboration error.
- NCHUNK, WIDTH/CHUNK, derived localparam: number of slice cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  registered sum.
- cout  output  1  registered carry-out.
- sub  input  1  subtract select; present only when ADD_SUB_EN is defined.

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, carry register=0, slice index=0, operand shift registers=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture a, b and cin into internal registers, set index=0, go to BUSY.
- BUSY:
  - in_ready=0; the a, b and cin ports are ignored.
  - Each cycle: {c, s} = a_sh[CHUNK-1:0] + b_sh[CHUNK-1:0] + carry.
  - Shift s into the top of the result register; shift a_sh and b_sh right by CHUNK; carry <= c; index++.
  - On the cycle where index==NCHUNK-1: copy the completed result to sum, copy c to cout, go to DONE.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_ready, go to IDLE and drop out_valid.
  - in_ready stays 0 until IDLE is re-entered; there is no overlap.
- Latency: accept edge E0; sum, cout and out_valid update on edge E0+NCHUNK. Minimum initiation interval is NCHUNK+2 cycles.
- sum and cout change only on the completion edge and keep the last result across IDLE.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- CHUNK==WIDTH: single BUSY cycle; latency 1.
- Reset asserted mid-operation: immediate abort to reset values; no out_valid is produced for the aborted operation.
- out_ready held low: the block stays in DONE indefinitely; there is no overwrite and no loss.
- out_ready high in IDLE or BUSY: no effect.
- in_valid high outside IDLE: ignored; the producer must hold its operands until in_ready.

Optional Feature:
- Macro: CHUNKED_ADDER_ADD_SUB_EN.
- Defined:
  - The sub port exists and is captured with the operands.
  - sub=1 computes a - b as a + ~b + 1; cin is ignored and the initial carry is 1.
  - cout=1 means no borrow.
  - sub=0 behaves as plain addition.
- Undefined: the sub port is absent; the block is add-only, identical to sub=0.

Decomposition:
- Shared package adder_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2;
  - a width-check macro/function for WIDTH % CHUNK.
- Sub-module chunk_full_adder:
  - combinational CHUNK-bit slice adder, inputs a, b, cin; outputs s, c;
  - instantiated once, inside the BUSY datapath.

Test Plan:
- WIDTH=16, CHUNK=4: a=0x158A, b=0x7095, cin=0 -> after 4 cycles out_valid=1, sum=0x861F, cout=0.
- a=0xB903, b=0xC6BD, cin=0 -> sum=0x7FC0, cout=1. Then a=0x52AF, b=0x9A4E, cin=1 -> sum=0xECFE, cout=0.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1 (carry propagates across all 4 slices).
- Backpressure: hold out_ready=0 for 10 cycles after completion -> out_valid stays 1, sum is stable, in_ready=0, and in_valid pulses are ignored. Release -> IDLE next cycle.
- Assert rst on the 2nd BUSY cycle -> out_valid never rises; sum=0, cout=0, in_ready=1 immediately.
- Parameter sweep CHUNK=16 (latency 1) and CHUNK=1 (latency 16) with random operands vs reference a+b+cin. With CHUNKED_ADDER_ADD_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0.
